// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced button presses into short/long/double-click pulses
//
// Purpose:
//   Watches the clean debounced button level and emits exactly one single-cycle
//   event per press sequence: short press, long press or double click.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   btn           in   debounced button level, synchronous to clk
//   pressed       out  registered copy of btn
//   short_press   out  one-cycle pulse after a single completed short press
//   long_press    out  one-cycle pulse when the hold reaches LONG_TICKS
//   double_click  out  one-cycle pulse on the second press of a double click

module button_press_classifier #(
    parameter int LONG_TICKS   = 100_000_000,
    parameter int DOUBLE_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_click
);

    localparam int MAX_TICKS = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
    localparam int CW        = $clog2(MAX_TICKS);

    // Terminal counts; the counter never has to hold MAX_TICKS itself.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HOLD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          btn_prev;
    logic          rise;
    logic          short_next;
    logic          long_next;
    logic          double_next;

    assign rise = btn & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            // Held-through-reset buttons must be released once before they count.
            btn_prev     <= 1'b1;
            pressed      <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            btn_prev     <= btn;
            pressed      <= btn;
            short_press  <= short_next;
            long_press   <= long_next;
            double_click <= double_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESS1;
                    cnt_next   = '0;
                end
            end

            // Release is tested first so it wins over the long-press timeout.
            PRESS1: begin
                if (!btn) begin
                    state_next = WAIT2;
                    cnt_next   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG_HOLD;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            LONG_HOLD: begin
                if (!btn) begin
                    state_next = IDLE;
                end
            end

            // A second press is tested first so it wins over the timeout.
            WAIT2: begin
                if (btn) begin
                    state_next  = PRESS2;
                    double_next = 1'b1;
                end else if (cnt == DOUBLE_LAST) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end

            // No long-press detection here; the sequence ends on release.
            PRESS2: begin
                if (!btn) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - self-checking bench for button_press_classifier

module tb_button_press_classifier;

    localparam int LONG = 20;
    localparam int DBL  = 8;
    localparam int MAXC = 2048;

    logic clk;
    logic reset;
    logic btn;
    logic pressed;
    logic short_press;
    logic long_press;
    logic double_click;

    // Per-cycle history: index n = values sampled at edge n and outputs seen after it.
    // Vector layout: [3]=pressed [2]=short_press [1]=long_press [0]=double_click
    bit       btn_h [MAXC];
    bit       rst_h [MAXC];
    logic [3:0] p_vec [MAXC];
    logic [3:0] e_vec [MAXC];
    int       cyc    = 0;
    int       checks = 0;
    int       fails  = 0;

    button_press_classifier #(
        .LONG_TICKS  (LONG),
        .DOUBLE_TICKS(DBL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit b, input bit r);
        btn   = b;
        reset = r;
        @(posedge clk);
        @(negedge clk);
        if (cyc < MAXC) begin
            btn_h[cyc] = b;
            rst_h[cyc] = r;
            p_vec[cyc] = {pressed, short_press, long_press, double_click};
            cyc++;
        end
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // ---------------- reference model: scans the recorded waveform ----------------
    function automatic bit rise_at(int n);
        bit prev;
        prev = (n == 0) ? 1'b1 : (rst_h[n-1] ? 1'b1 : btn_h[n-1]);
        return !rst_h[n] && btn_h[n] && !prev;
    endfunction

    function automatic int first_low(int from);
        for (int n = from; n < cyc; n++)
            if (rst_h[n] || !btn_h[n]) return n;
        return cyc;
    endfunction

    function automatic int first_high(int from, int to);
        for (int n = from; n <= to && n < cyc; n++)
            if (rst_h[n] || btn_h[n]) return n;
        return to + 1;
    endfunction

    task automatic compute_model();
        int i, k, r, h, q;
        for (int n = 0; n < cyc; n++)
            e_vec[n] = {(rst_h[n] ? 1'b0 : btn_h[n]), 3'b000};
        i = 0;
        while (i < cyc) begin
            if (!rise_at(i)) begin
                i++;
            end else begin
                k = i;
                r = first_low(k + 1);
                if (r - k > LONG && k + LONG < cyc) e_vec[k + LONG][1] = 1'b1;
                if (r >= cyc)              i = cyc;
                else if (rst_h[r])         i = r;
                else if (r - k > LONG)     i = r + 1;
                else begin
                    h = first_high(r + 1, r + DBL);
                    if (h <= r + DBL && h < cyc) begin
                        if (rst_h[h]) begin
                            i = h;
                        end else begin
                            e_vec[h][0] = 1'b1;
                            q = first_low(h + 1);
                            i = (q >= cyc) ? cyc : (rst_h[q] ? q : q + 1);
                        end
                    end else if (r + DBL < cyc) begin
                        e_vec[r + DBL][2] = 1'b1;
                        i = r + DBL + 1;
                    end else begin
                        i = cyc;
                    end
                end
            end
        end
    endtask

    function automatic int count_bit(int b, int from, int to);
        int c = 0;
        for (int n = from; n < to; n++) if (p_vec[n][b] === 1'b1) c++;
        return c;
    endfunction

    function automatic int last_bit(int b, int from, int to);
        int p = -1;
        for (int n = from; n < to; n++) if (p_vec[n][b] === 1'b1) p = n;
        return p;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int s = cyc;
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        checks++;
        if (p_vec[2] !== 4'b0000) begin
            fails++; $display("FAIL reset_state: got %b expected 0000", p_vec[2]);
        end
        steps(1'b1, 50);
        steps(1'b0, 30);
        checks++;
        if (p_vec[3] !== 4'b1000) begin
            fails++; $display("FAIL reset_pressed_rise: got %b expected 1000", p_vec[3]);
        end
        checks++;
        if (p_vec[52][3] !== 1'b1 || p_vec[53][3] !== 1'b0) begin
            fails++; $display("FAIL reset_pressed_fall: got %b%b expected 10", p_vec[52][3], p_vec[53][3]);
        end
        checks++;
        if (count_bit(2, s, cyc) + count_bit(1, s, cyc) + count_bit(0, s, cyc) != 0) begin
            fails++; $display("FAIL reset_held_events: got %0d pulses expected 0",
                              count_bit(2, s, cyc) + count_bit(1, s, cyc) + count_bit(0, s, cyc));
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL reset_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_short();
        int s, b;
        s = cyc;
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 5);
        steps(1'b0, 20);
        checks++;
        if (count_bit(2, b, cyc) != 1 || last_bit(2, b, cyc) != b + 13) begin
            fails++; $display("FAIL short_pulse: got %0d at %0d expected 1 at %0d",
                              count_bit(2, b, cyc), last_bit(2, b, cyc) - b, 13);
        end
        checks++;
        if (count_bit(1, b, cyc) + count_bit(0, b, cyc) != 0) begin
            fails++; $display("FAIL short_others: got %0d expected 0", count_bit(1, b, cyc) + count_bit(0, b, cyc));
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL short_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_long();
        int s, b;
        s = cyc;
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 40);
        steps(1'b0, 20);
        checks++;
        if (count_bit(1, b, cyc) != 1 || last_bit(1, b, cyc) != b + 20) begin
            fails++; $display("FAIL long_pulse: got %0d at %0d expected 1 at %0d",
                              count_bit(1, b, cyc), last_bit(1, b, cyc) - b, 20);
        end
        checks++;
        if (count_bit(2, b, cyc) + count_bit(0, b, cyc) != 0) begin
            fails++; $display("FAIL long_others: got %0d expected 0", count_bit(2, b, cyc) + count_bit(0, b, cyc));
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL long_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_double();
        int s, b;
        s = cyc;
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 5);
        steps(1'b0, 3);
        steps(1'b1, 40);
        steps(1'b0, 20);
        checks++;
        if (count_bit(0, b, cyc) != 1 || last_bit(0, b, cyc) != b + 8) begin
            fails++; $display("FAIL double_pulse: got %0d at %0d expected 1 at %0d",
                              count_bit(0, b, cyc), last_bit(0, b, cyc) - b, 8);
        end
        checks++;
        if (count_bit(2, b, cyc) + count_bit(1, b, cyc) != 0) begin
            fails++; $display("FAIL double_others: got %0d expected 0", count_bit(2, b, cyc) + count_bit(1, b, cyc));
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL double_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_boundary();
        int s, b;
        s = cyc;
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 20);            // edges 0..19 high, release sampled at edge 20
        steps(1'b0, 20);
        checks++;
        if (count_bit(1, b, cyc) != 0) begin
            fails++; $display("FAIL boundary_long: got %0d expected 0", count_bit(1, b, cyc));
        end
        checks++;
        if (count_bit(2, b, cyc) != 1 || last_bit(2, b, cyc) != b + 28) begin
            fails++; $display("FAIL boundary_long_short: got %0d at %0d expected 1 at 28",
                              count_bit(2, b, cyc), last_bit(2, b, cyc) - b);
        end
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 3);             // release at edge 3
        steps(1'b0, 8);             // edges 3..10 low
        steps(1'b1, 5);             // second press sampled at edge 11 = r+8
        steps(1'b0, 15);
        checks++;
        if (count_bit(0, b, cyc) != 1 || last_bit(0, b, cyc) != b + 11) begin
            fails++; $display("FAIL boundary_double: got %0d at %0d expected 1 at 11",
                              count_bit(0, b, cyc), last_bit(0, b, cyc) - b);
        end
        checks++;
        if (count_bit(2, b, cyc) != 0) begin
            fails++; $display("FAIL boundary_double_short: got %0d expected 0", count_bit(2, b, cyc));
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL boundary_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_reset_in_wait2();
        int s, b, b2;
        s = cyc;
        steps(1'b0, 10);
        b = cyc;
        steps(1'b1, 5);
        steps(1'b0, 3);
        step(1'b0, 1'b1);
        steps(1'b0, 20);
        checks++;
        if (count_bit(2, b, cyc) + count_bit(1, b, cyc) + count_bit(0, b, cyc) != 0) begin
            fails++; $display("FAIL wait2_reset_events: got %0d expected 0",
                              count_bit(2, b, cyc) + count_bit(1, b, cyc) + count_bit(0, b, cyc));
        end
        b2 = cyc;
        steps(1'b1, 4);
        steps(1'b0, 20);
        checks++;
        if (count_bit(2, b2, cyc) != 1 || last_bit(2, b2, cyc) != b2 + 12) begin
            fails++; $display("FAIL wait2_reset_recover: got %0d at %0d expected 1 at 12",
                              count_bit(2, b2, cyc), last_bit(2, b2, cyc) - b2);
        end
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL wait2_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_random();
        int s, len, sel;
        bit lvl;
        s = cyc;
        lvl = 1'b0;
        while (cyc < s + 800) begin
            lvl = ~lvl;
            sel = $urandom_range(0, 9);
            case (sel)
                0: len = LONG - 1;
                1: len = LONG;
                2: len = LONG + 1;
                3: len = DBL - 1;
                4: len = DBL;
                5: len = DBL + 1;
                default: len = $urandom_range(1, 28);
            endcase
            for (int i = 0; i < len; i++)
                step(lvl, ($urandom_range(0, 59) == 0));
        end
        steps(1'b0, 30);
        compute_model();
        for (int k = s; k < cyc; k++) begin
            checks++;
            if (p_vec[k] !== e_vec[k]) begin
                fails++; $display("FAIL random_trace cycle %0d: got %b expected %b", k, p_vec[k], e_vec[k]);
            end
        end
    endtask

    initial begin
        btn   = 1'b1;
        reset = 1'b1;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundary();
        test_reset_in_wait2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
